// File: rtl/rms_pkg.sv
// Purpose : shared types, constants and helpers for the RMSNorm scale sequencer.
// Latency : n/a (package only).
// Backpr. : n/a.
package rms_pkg;

    // Default geometry: 8-bit samples, 64-element vectors, 14-bit inv_sqrt input.
    localparam int X_W_DEF    = 8;
    localparam int LOG2_N_DEF = 6;
    localparam int D_W_DEF    = 14;

    // Sum of N squares of an X_W-bit signed value fits in 2*X_W+LOG2_N bits.
    function automatic int acc_width(input int x_w, input int log2_n);
        return 2 * x_w + log2_n;
    endfunction

    // Largest value the inv_sqrt input can carry.
    function automatic int d_max(input int d_w);
        return (1 << d_w) - 1;
    endfunction

    localparam int          ACC_W   = acc_width(X_W_DEF, LOG2_N_DEF);
    localparam int          D_MAX   = d_max(D_W_DEF);
    localparam int unsigned Q15_ONE = 32768;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/inv_sqrt.sv
// Purpose : 1/sqrt(d) in Q1.15 (1.0 = 32768), saturating to 0xFFFF for d = 0.
// Latency : 2 cycles after the input is sampled; valid_o is a one-cycle pulse.
// Backpr. : none; the pipeline always advances and has no reset, so callers gate valid_o.
// Ports   : clk_i; valid_i/d_i request; valid_o/result_o response.
module inv_sqrt
    import rms_pkg::*;
#(
    parameter int D_W      = D_W_DEF,
    parameter     HEX_FILE = "inv_sqrt_lut.hex"
) (
    input  logic           clk_i,
    input  logic           valid_i,
    input  logic [D_W-1:0] d_i,
    output logic           valid_o,
    output logic [15:0]    result_o
);

    // The table image is regenerated from the arithmetic below, so the file
    // name only has to be non-empty to stay interchangeable with the ROM build.
    if ($bits(HEX_FILE) == 0) begin : g_hex_chk
        $error("inv_sqrt: HEX_FILE must name an image");
    end

    // result = floor(sqrt(2^30 / d)) == floor(32768 / sqrt(d)).
    localparam int unsigned NUM = Q15_ONE * Q15_ONE;

    function automatic logic [15:0] isqrt31(input logic [30:0] v);
        logic [15:0] r;
        logic [15:0] t;
        logic [31:0] sq;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t  = r | (16'd1 << b);
            sq = 32'(t) * 32'(t);
            if (sq <= {1'b0, v}) begin
                r = t;
            end
        end
        return r;
    endfunction

    logic           v0_q;
    logic [D_W-1:0] d0_q;
    logic           v1_q;
    logic           z1_q;
    logic [30:0]    q1_q;
    logic [30:0]    q1_d;
    logic           v2_q;
    logic [15:0]    r2_q;
    logic [15:0]    r2_d;

    always_comb begin
        q1_d = '0;
        if (d0_q != '0) begin
            q1_d = 31'(NUM) / 31'(d0_q);
        end
    end

    always_comb begin
        r2_d = z1_q ? 16'hFFFF : isqrt31(q1_q);
    end

    always_ff @(posedge clk_i) begin
        v0_q <= valid_i;
        d0_q <= d_i;
        v1_q <= v0_q;
        z1_q <= (d0_q == '0);
        q1_q <= q1_d;
        v2_q <= v1_q;
        r2_q <= r2_d;
    end

    assign valid_o  = v2_q;
    assign result_o = r2_q;

endmodule

// File: rtl/rms_scale_ctrl.sv
// Purpose : RMSNorm scale sequencer: sum of squares over N samples, truncated mean,
//           saturate (+EPS when RMS_EPS_EN is defined), one inv_sqrt request, hold result.
// Latency : scale_valid_o rises on the 4th rising edge after the final-sample handshake.
// Backpr. : x_ready_o only in ACCUM; result held stable until scale_ready_i.
// Ports   : clk_i/rst_i (async active-high); start_i; x_valid_i/x_i/x_ready_o sample
//           stream; busy_o; scale_valid_o/scale_o/scale_ready_i result handshake.
module rms_scale_ctrl
    import rms_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int LOG2_N   = LOG2_N_DEF,
    parameter int D_W      = D_W_DEF,
    parameter     HEX_FILE = "inv_sqrt_lut.hex",
    parameter int EPS      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  x_valid_i,
    input  logic signed [X_W-1:0] x_i,
    output logic                  x_ready_o,
    output logic                  busy_o,
    output logic                  scale_valid_o,
    output logic [15:0]           scale_o,
    input  logic                  scale_ready_i
);

    localparam int              AW       = acc_width(X_W, LOG2_N);
    localparam logic [AW:0]     D_LIMIT  = (AW + 1)'(d_max(D_W));
    localparam logic [LOG2_N-1:0] CNT_ONE  = 1;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    // EPS only matters with RMS_EPS_EN, but an out-of-range value is a
    // configuration mistake in either build.
    if (EPS < 0 || EPS > d_max(D_W)) begin : g_eps_chk
        $error("rms_scale_ctrl: EPS out of range");
    end

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic              x_rdy_q, x_rdy_d;
    logic              busy_q, busy_d;
    logic              scale_vld_q, scale_vld_d;
    logic [15:0]       scale_q, scale_d;

    logic signed [2*X_W-1:0] sq;
    logic [AW-1:0]           sq_ext;
    logic [AW:0]             mean_ext;
    logic [D_W-1:0]          d_sat;
    logic                    x_hs;
    logic                    inv_vld_raw;
    logic                    inv_vld;
    logic [15:0]             inv_res;

    // A square is never negative and never exceeds 2^(2*X_W-2), so it is
    // zero-extended into the accumulator.
    assign sq     = x_i * x_i;
    assign sq_ext = {{(AW - 2 * X_W){1'b0}}, sq};
    assign x_hs   = x_valid_i && x_rdy_q;

    // Truncated mean, optional epsilon, then clamp to the inv_sqrt range.
    // One spare bit keeps mean+EPS from wrapping before the compare.
    always_comb begin
        mean_ext = {1'b0, acc_q >> LOG2_N};
`ifdef RMS_EPS_EN
        mean_ext = mean_ext + (AW + 1)'(EPS);
`endif
        d_sat = (mean_ext > D_LIMIT) ? D_LIMIT[D_W-1:0] : mean_ext[D_W-1:0];
    end

    // The inv_sqrt pipeline has no reset; anything it emits outside WAIT is
    // left over from an aborted request and must not be captured.
    assign inv_vld = inv_vld_raw && (state_q == WAIT);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        scale_vld_d = scale_vld_q;
        scale_d     = scale_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (x_hs) begin
                    acc_d = acc_q + sq_ext;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (inv_vld) begin
                    scale_d     = inv_res;
                    scale_vld_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // start_i here is ignored on purpose: a new vector starts from IDLE.
                if (scale_ready_i) begin
                    scale_vld_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        x_rdy_d = (state_d == ACCUM);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            x_rdy_q     <= 1'b0;
            busy_q      <= 1'b0;
            scale_vld_q <= 1'b0;
            scale_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            x_rdy_q     <= x_rdy_d;
            busy_q      <= busy_d;
            scale_vld_q <= scale_vld_d;
            scale_q     <= scale_d;
        end
    end

    inv_sqrt #(
        .D_W      (D_W),
        .HEX_FILE (HEX_FILE)
    ) u_inv_sqrt (
        .clk_i    (clk_i),
        .valid_i  (state_q == ISSUE),
        .d_i      (d_sat),
        .valid_o  (inv_vld_raw),
        .result_o (inv_res)
    );

    assign x_ready_o     = x_rdy_q;
    assign busy_o        = busy_q;
    assign scale_valid_o = scale_vld_q;
    assign scale_o       = scale_q;

endmodule

// File: tb/tb_rms_scale_ctrl.sv
// Purpose : self-checking bench for rms_scale_ctrl against an arithmetic reference.
// Latency : n/a.
// Backpr. : exercises sample gaps and a stalled result consumer.
module tb_rms_scale_ctrl;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              x_valid_i;
    logic signed [7:0] x_i;
    logic              x_ready_o;
    logic              busy_o;
    logic              scale_valid_o;
    logic [15:0]       scale_o;
    logic              scale_ready_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic signed [7:0] vec [64];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    rms_scale_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .x_valid_i     (x_valid_i),
        .x_i           (x_i),
        .x_ready_o     (x_ready_o),
        .busy_o        (busy_o),
        .scale_valid_o (scale_valid_o),
        .scale_o       (scale_o),
        .scale_ready_i (scale_ready_i)
    );

    // Reference: mean of squares, optional epsilon, clamp, then the largest r
    // with r*r*d <= 2^30 (i.e. floor(32768/sqrt(d))).
    function automatic int model_scale(input longint sum_sq);
        longint d;
        longint r;
        d = sum_sq / 64;
`ifdef RMS_EPS_EN
        d = d + 1;
`endif
        if (d > 16383) d = 16383;
        if (d == 0) return 65535;
        r = longint'($floor(32768.0 / $sqrt(real'(d))));
        while ((r + 1) * (r + 1) * d <= (longint'(1) << 30)) r++;
        while (r * r * d > (longint'(1) << 30)) r--;
        return int'(r);
    endfunction

    function automatic longint vec_sum();
        longint s = 0;
        for (int i = 0; i < 64; i++) s += longint'(vec[i]) * longint'(vec[i]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic consume();
        scale_ready_i = 1'b1;
        tick();
        scale_ready_i = 1'b0;
    endtask

    // mode 0: continuous, 1: valid every other cycle, 2: random gaps.
    task automatic send_vector(input int n, input int mode, output int last_e,
                               output bit drop, output bit to);
        int  i = 0;
        int  guard = 0;
        bit  v;
        bit  hs;
        drop = 0;
        to = 0;
        last_e = cyc;
        while (i < n && guard < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            x_valid_i = v;
            x_i = v ? vec[i] : 8'($urandom);
            if (!x_ready_o) drop = 1;
            hs = v && x_ready_o;
            tick();
            if (hs) begin
                i++;
                last_e = cyc;
            end
            guard++;
        end
        x_valid_i = 1'b0;
        x_i = '0;
        if (i < n) to = 1;
    endtask

    task automatic get_scale(output int at, output bit to);
        to = 1;
        at = -1;
        for (int k = 0; k < 20; k++) begin
            if (scale_valid_o) begin
                at = cyc;
                to = 0;
                break;
            end
            tick();
        end
    endtask

    // Start, stream all 64 samples, wait for the result (no comparisons here).
    task automatic run_vec(input int mode, output int lat, output bit drop, output bit to);
        int le, ge;
        bit t1, t2;
        do_start();
        send_vector(64, mode, le, drop, t1);
        get_scale(ge, t2);
        lat = ge - le;
        to = t1 | t2;
        if (to) begin
            rst_i = 1'b1;
            tick();
            rst_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({x_ready_o, busy_o, scale_valid_o} !== 3'b000 || scale_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b vld=%b scale=%0d want 0/0/0/0",
                     x_ready_o, busy_o, scale_valid_o, scale_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || x_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b rdy=%b want 0/0", busy_o, x_ready_o);
        end
    endtask

    task automatic test_ones();
        int lat, exp;
        bit drop, to;
        for (int i = 0; i < 64; i++) vec[i] = 8'sd1;
        exp = model_scale(vec_sum());
        run_vec(0, lat, drop, to);
        checks++;
        if (to || lat != 4) begin
            errors++;
            $display("FAIL ones_latency: got %0d edges (timeout=%0d) want 4", lat, to);
        end
        checks++;
        if (scale_o !== 16'(exp) || scale_o !== 16'd32768) begin
            errors++;
            $display("FAIL ones_scale: got %0d want %0d", scale_o, exp);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL ones_busy_hold: got %b want 1", busy_o);
        end
        consume();
        checks++;
        if (scale_valid_o !== 1'b0 || busy_o !== 1'b0 || scale_o !== 16'(exp)) begin
            errors++;
            $display("FAIL ones_release: got vld=%b busy=%b scale=%0d want 0/0/%0d",
                     scale_valid_o, busy_o, scale_o, exp);
        end
    endtask

    task automatic test_neg2();
        int lat, exp;
        bit drop, to;
        for (int i = 0; i < 64; i++) vec[i] = -8'sd2;
        exp = model_scale(vec_sum());
        for (int mode = 0; mode < 2; mode++) begin
            run_vec(mode, lat, drop, to);
            checks++;
            if (to || scale_o !== 16'(exp) || lat != 4) begin
                errors++;
                $display("FAIL neg2_mode%0d: got scale=%0d lat=%0d to=%0d want %0d lat 4",
                         mode, scale_o, lat, to, exp);
            end
            checks++;
            if (drop) begin
                errors++;
                $display("FAIL neg2_ready_mode%0d: got x_ready_o low in ACCUM want high", mode);
            end
            consume();
        end
    endtask

    task automatic test_extremes();
        int lat, exp;
        bit drop, to;
        for (int i = 0; i < 64; i++) vec[i] = -8'sd128;
        exp = model_scale(vec_sum());
        run_vec(0, lat, drop, to);
        checks++;
        if (to || scale_o !== 16'(exp) || scale_o !== 16'd256) begin
            errors++;
            $display("FAIL clamp_scale: got %0d want %0d", scale_o, exp);
        end
        consume();
        for (int i = 0; i < 64; i++) vec[i] = 8'sd0;
        exp = model_scale(vec_sum());
        run_vec(0, lat, drop, to);
        checks++;
        if (to || scale_o !== 16'(exp)) begin
            errors++;
            $display("FAIL zero_scale: got %0d want %0d", scale_o, exp);
        end
        consume();
    endtask

    task automatic test_hold();
        int lat, exp;
        bit drop, to, bad;
        for (int i = 0; i < 64; i++) vec[i] = (i % 2 == 1) ? -8'sd3 : 8'sd3;
        exp = model_scale(vec_sum());
        run_vec(0, lat, drop, to);
        checks++;
        if (to || scale_o !== 16'(exp)) begin
            errors++;
            $display("FAIL hold_scale: got %0d want %0d", scale_o, exp);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            start_i = (k == 4);
            tick();
            if (scale_valid_o !== 1'b1 || scale_o !== 16'(exp) || busy_o !== 1'b1
                || x_ready_o !== 1'b0) bad = 1;
        end
        start_i = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_stable: got vld=%b scale=%0d busy=%b want 1/%0d/1",
                     scale_valid_o, scale_o, busy_o, exp);
        end
        // Start coinciding with the accepting handshake must not launch a vector.
        start_i = 1'b1;
        scale_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        scale_ready_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || x_ready_o !== 1'b0 || scale_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_start_ignored: got busy=%b rdy=%b vld=%b want 0/0/0",
                     busy_o, x_ready_o, scale_valid_o);
        end
    endtask

    task automatic test_abort_accum();
        int lat, exp, le;
        bit drop, to;
        for (int i = 0; i < 64; i++) vec[i] = 8'($urandom);
        do_start();
        send_vector(30, 0, le, drop, to);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({x_ready_o, busy_o, scale_valid_o} !== 3'b000 || scale_o !== 16'h0000) begin
            errors++;
            $display("FAIL abort_async: got rdy=%b busy=%b vld=%b scale=%0d want 0/0/0/0",
                     x_ready_o, busy_o, scale_valid_o, scale_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
        for (int i = 0; i < 64; i++) vec[i] = 8'sd4;
        exp = model_scale(vec_sum());
        run_vec(2, lat, drop, to);
        checks++;
        if (to || scale_o !== 16'(exp) || scale_o !== 16'd8192 || lat != 4) begin
            errors++;
            $display("FAIL abort_next_vector: got %0d lat=%0d want %0d lat 4", scale_o, lat, exp);
        end
        consume();
    endtask

    task automatic test_reset_wait();
        int le;
        bit drop, to, bad;
        for (int i = 0; i < 64; i++) vec[i] = 8'sd5;
        do_start();
        send_vector(64, 0, le, drop, to);
        tick();                       // now in WAIT, request in flight
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({x_ready_o, busy_o, scale_valid_o} !== 3'b000 || scale_o !== 16'h0000) begin
            errors++;
            $display("FAIL wait_reset_async: got rdy=%b busy=%b vld=%b scale=%0d want 0/0/0/0",
                     x_ready_o, busy_o, scale_valid_o, scale_o);
        end
        tick();
        rst_i = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (scale_valid_o !== 1'b0 || busy_o !== 1'b0 || scale_o !== 16'h0000) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wait_stale_result: got vld=%b busy=%b scale=%0d want 0/0/0",
                     scale_valid_o, busy_o, scale_o);
        end
    endtask

    task automatic test_random();
        int lat, exp;
        bit drop, to;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 64; i++) vec[i] = 8'($urandom);
            if (n == 4) for (int i = 0; i < 64; i++) vec[i] = 8'($urandom_range(0, 40)) - 8'sd20;
            exp = model_scale(vec_sum());
            run_vec(2, lat, drop, to);
            checks++;
            if (to || scale_o !== 16'(exp) || lat != 4) begin
                errors++;
                $display("FAIL random_%0d: got %0d lat=%0d want %0d lat 4", n, scale_o, lat, exp);
            end
            if (!to) consume();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        x_valid_i = 1'b0;
        x_i = '0;
        scale_ready_i = 1'b0;
        test_reset();
        test_ones();
        test_neg2();
        test_extremes();
        test_hold();
        test_abort_accum();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rms_scale_ctrl.md
Name: rms_scale_ctrl

Overview:
Sequencer that computes the RMSNorm scale factor for one activation vector using the shared inv_sqrt LUT unit.
- Streams N signed samples and accumulates their sum of squares.
- Forms the truncated mean, saturates it to the inv_sqrt input width, then issues a single request to inv_sqrt and holds the Q1.15 result until the consumer takes it.
- Sits between the activation buffer and the per-element normaliser multiply.

Parameters:
X_W, 8, sample width (signed two's complement)
LOG2_N, 6, log2 of vector length N (N=64)
D_W, 14, inv_sqrt input width; mean saturates to 2^D_W-1
HEX_FILE, "inv_sqrt_lut.hex", LUT image passed through to inv_sqrt
EPS, 1, epsilon added to the mean (used only with RMS_EPS_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  begin a new vector; honoured only in IDLE
x_valid_i  in  1  sample valid
x_i  in  X_W  signed sample
x_ready_o  out  1  sample ready; high only in ACCUM
busy_o  out  1  high in every state except IDLE
scale_valid_o  out  1  scale result valid
scale_o  out  16  1/sqrt(mean) in Q1.15 (1.0 = 32768)
scale_ready_i  in  1  consumer accepts the scale

Behaviour:
- Reset values: state=IDLE, acc=0, cnt=0, x_ready_o=0, busy_o=0, scale_valid_o=0, scale_o=0.
- Reset is asynchronous at any point, including mid-ACCUM or WAIT, and discards all partial work.
- The inv_sqrt pipeline is flushed by gating: its valid_o is ignored unless the state is WAIT.
- State IDLE: on start_i, clear acc and cnt, go to ACCUM.
- State ACCUM:
  - x_ready_o=1. A handshake is x_valid_i && x_ready_o on a rising edge.
  - On each handshake: acc += x_i*x_i and cnt++.
  - acc width is 2*X_W+LOG2_N bits (22). It cannot overflow.
  - The handshake with cnt==N-1 moves to ISSUE.
  - Gaps in x_valid_i are allowed, with no timeout.
- State ISSUE (1 cycle):
  - d = acc >> LOG2_N, floor/truncation.
  - If d > 2^D_W-1, clamp to 2^D_W-1.
  - Drive inv_sqrt valid_i=1 with d_i=d. Go to WAIT.
- State WAIT:
  - When inv_sqrt valid_o=1, register scale_o=result_o and set scale_valid_o=1. Go to HOLD.
  - inv_sqrt has 2-cycle latency, so scale_valid_o rises on the 4th rising edge after the final-sample handshake edge. This is the required latency.
- State HOLD:
  - scale_valid_o and scale_o stay stable until scale_ready_i.
  - On handshake, clear scale_valid_o and go to IDLE. scale_o keeps its last value.
- start_i outside IDLE is ignored. start_i in the same cycle as the HOLD handshake is also ignored; a new vector needs start_i in IDLE.
- d=0 (all-zero vector) yields scale_o=0xFFFF, the inv_sqrt saturation value.
- Only one inv_sqrt request is ever in flight.

Optional Feature:
RMS_EPS_EN
- Defined: d = min(acc>>LOG2_N + EPS, 2^D_W-1). An all-zero vector then gives inv_sqrt(EPS); with EPS=1 that is 32768.
- Undefined: no epsilon is added, the EPS parameter is unused, and zero mean gives 0xFFFF.

Decomposition:
- Shared package rms_pkg holds:
  - state enum (IDLE, ACCUM, ISSUE, WAIT, HOLD)
  - ACC_W = 2*X_W+LOG2_N
  - D_MAX = 2^D_W-1
  - Q1.15 ONE = 32768
- Single sub-module: existing inv_sqrt, instantiated with D_W and HEX_FILE, clocked by clk_i.
- The saturation/epsilon logic stays in the controller.

Test Plan:
- Reset, start, 64 samples of x=1 -> d=1, scale_o=32768, scale_valid_o on 4th edge after last handshake.
- 64 samples of x=-2 -> mean 4 -> scale_o=16384. Repeat with x_valid_i toggled every other cycle -> same result; x_ready_o high throughout ACCUM.
- 64 samples of x=-128 -> mean 16384, clamped to 16383 -> scale_o=256. 64 samples of x=0 -> scale_o=0xFFFF (RMS_EPS_EN undefined) or 32768 (defined, EPS=1).
- Alternating x=3/-3 -> mean 9 -> 10922. Then hold scale_ready_i low 10 cycles -> scale_valid_o and scale_o stable. Pulse start_i during HOLD -> ignored, busy_o stays 1.
- Assert rst_i after 30 samples, deassert, start new vector of x=4 -> mean 16 -> 8192, no contamination from the aborted vector.
- Assert rst_i in WAIT -> outputs return to reset values immediately. Stale inv_sqrt valid_o after reset release -> scale_valid_o stays 0.
